mem_access_controller: RTL and testbench

- CPU-side initiator for the 512x32 word memory; it is the requesting end of the memory's read/write/enable/done interface.
- Accepts single-word read and write requests from the datapath (MAR address, MDR write data) and registers address, data and command.
- Produces a clean rising edge on the memory enable, waits for done with a timeout, then returns read data or a write acknowledge to the control unit.
- Sits between the datapath MAR/MDR registers and the memory block.

---
 rtl/mem_access_controller.sv | 145 ++++++++++++++
 tb/tb_mem_access_controller.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// CPU-side initiator for the word memory. It registers a single read or write
// request, strobes the memory enable once, waits for done with a timeout, and then reports the result.
module mem_access_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  busy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_ack,
  output logic                  err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_done
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_COMPLETE
  } state_t;

  state_t                state_q;
  logic                  is_read_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  busy_q;
  logic                  rd_valid_q;
  logic                  wr_ack_q;
  logic                  err_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic                  mem_enable_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign cnt_d = cnt_q + CNT_W'(1);

  // Access sequencer; every output is a register updated on the transition into its state.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q      <= S_IDLE;
      is_read_q    <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_ack_q     <= 1'b0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_enable_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Read has priority; a simultaneous write is dropped.
          if (req_read || req_write) begin
            is_read_q   <= req_read;
            mem_read_q  <= req_read;
            mem_write_q <= !req_read;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            busy_q      <= 1'b1;
            state_q     <= S_SETUP;
          end
        end
        S_SETUP: begin
          mem_enable_q <= 1'b1;
          state_q      <= S_STROBE;
        end
        S_STROBE: begin
          mem_enable_q <= 1'b0;
          cnt_q        <= '0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_done) begin
            if (is_read_q) begin
              rd_data_q <= mem_data_out;
            end
            rd_valid_q  <= is_read_q;
            wr_ack_q    <= !is_read_q;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= S_COMPLETE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(TIMEOUT)) begin
              rd_valid_q  <= is_read_q;
              wr_ack_q    <= !is_read_q;
              err_q       <= 1'b1;
              mem_read_q  <= 1'b0;
              mem_write_q <= 1'b0;
              state_q     <= S_COMPLETE;
            end
          end
        end
        S_COMPLETE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q       <= 1'b0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          mem_enable_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign wr_ack      = wr_ack_q;
  assign err         = err_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_enable  = mem_enable_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: a behavioural 512x32 memory plus a queue of
// expected completions that is checked as each rd_valid/wr_ack appears.
module tb_mem_access_controller;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;

  logic          clock = 1'b0;
  logic          clear;
  logic          req_read, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          busy, rd_valid, wr_ack, err;
  logic [DW-1:0] rd_data;
  logic          mem_read, mem_write, mem_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_done = 1'b0;

  logic [DW-1:0] mem [0:511];
  logic          hold_done = 1'b0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  typedef struct packed {
    logic          is_read;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_access_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
    .clock        (clock),
    .clear        (clear),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wr_ack       (wr_ack),
    .err          (err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_enable   (mem_enable),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_done     (mem_done)
  );

  always #5 clock = ~clock;

  // Memory model: acts on the enable strobe, raises done for the following cycle.
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_enable && !hold_done) begin
      if (mem_write) mem[mem_address] <= mem_data_in;
      else if (mem_read) mem_data_out <= mem[mem_address];
      mem_done <= 1'b1;
    end else begin
      mem_done <= 1'b0;
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // Presents a request for edge 0 and returns in cycle 1 with the request removed.
  task automatic start_req(input logic r, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    req_read = r; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clock);
    req_read = 1'b0; req_write = 1'b0;
  endtask

  task automatic wait_done(input int start, output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = start; i < start + 40; i++) begin
      @(negedge clock);
      if (rd_valid || wr_ack) begin
        lat = i; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clear = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, rd_valid, wr_ack, err, mem_read, mem_write, mem_enable, rd_data, mem_address, mem_data_in} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rdv=%b ack=%b err=%b en=%b rd_data=%h addr=%h wdata=%h, required all zero",
               busy, rd_valid, wr_ack, err, mem_enable, rd_data, mem_address, mem_data_in);
    end
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read;
    exp_t e;
    preload(9'h1A5, 32'hDEADBEEF);
    exp_q.push_back('{is_read: 1'b1, data: 32'hDEADBEEF, err: 1'b0});
    start_req(1'b1, 1'b0, 9'h1A5, 32'h0);
    checks++;
    if ({busy, mem_read, mem_write, mem_enable, mem_address} !== {4'b1100, 9'h1A5}) begin
      errors++;
      $display("FAIL read_setup: busy/rd/wr/en=%b%b%b%b addr=%h, required 1100 addr=1a5",
               busy, mem_read, mem_write, mem_enable, mem_address);
    end
    @(negedge clock);
    checks++;
    if (mem_enable !== 1'b1) begin
      errors++; $display("FAIL read_strobe: mem_enable=%b required 1", mem_enable);
    end
    @(negedge clock);
    checks++;
    if (mem_enable !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL read_wait: mem_enable=%b rd_valid=%b required 0 0", mem_enable, rd_valid);
    end
    @(negedge clock);
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++; $display("FAIL read_latency: rd_valid=%b in cycle 4, required 1", rd_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.data || err !== e.err || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL read_data: rd_data=%h err=%b mem_read=%b, required %h %b 0", rd_data, err, mem_read, e.data, e.err);
      end
    end
    @(negedge clock);
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL read_end: rd_valid=%b busy=%b required 0 0", rd_valid, busy);
    end
  endtask

  task automatic test_write_then_read;
    exp_t e;
    int   lat;
    bit   ok;
    exp_q.push_back('{is_read: 1'b0, data: 32'h12345678, err: 1'b0});
    start_req(1'b0, 1'b1, 9'h000, 32'h12345678);
    wait_done(2, lat, ok);
    checks++;
    if (!ok || wr_ack !== 1'b1 || rd_valid !== 1'b0 || err !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL write_ack: done=%0d wr_ack=%b rdv=%b err=%b latency=%0d, required wr_ack in cycle 4", ok, wr_ack, rd_valid, err, lat);
    end else begin
      e = exp_q.pop_front();
    end
    req_read = 1'b1; req_addr = 9'h000;
    exp_q.push_back('{is_read: 1'b1, data: 32'h12345678, err: 1'b0});
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || wr_ack !== 1'b0) begin
      errors++; $display("FAIL gap_idle: busy=%b wr_ack=%b required 0 0", busy, wr_ack);
    end
    @(negedge clock);
    req_read = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL gap_one_cycle: busy=%b required 1", busy);
    end
    wait_done(2, lat, ok);
    checks++;
    if (!ok || rd_valid !== 1'b1) begin
      errors++; $display("FAIL wr_rd_done: rd_valid=%b required 1", rd_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.data || err !== e.err || mem[0] !== 32'h12345678) begin
        errors++;
        $display("FAIL wr_rd_data: rd_data=%h mem[0]=%h err=%b, required %h %h %b", rd_data, mem[0], err, e.data, 32'h12345678, e.err);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_simultaneous;
    exp_t e;
    int   lat;
    bit   ok;
    preload(9'h1FF, 32'h5);
    exp_q.push_back('{is_read: 1'b1, data: 32'h5, err: 1'b0});
    start_req(1'b1, 1'b1, 9'h1FF, 32'hAAAAAAAA);
    wait_done(2, lat, ok);
    checks++;
    if (!ok || rd_valid !== 1'b1 || wr_ack !== 1'b0) begin
      errors++; $display("FAIL simul_kind: rd_valid=%b wr_ack=%b required 1 0", rd_valid, wr_ack);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.data || mem[9'h1FF] !== 32'h5) begin
        errors++; $display("FAIL simul_data: rd_data=%h mem[1ff]=%h, required %h 5", rd_data, mem[9'h1FF], e.data);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_timeout;
    exp_t e;
    int   lat;
    bit   ok;
    hold_done = 1'b1;
    exp_q.push_back('{is_read: 1'b1, data: 32'h5, err: 1'b1});
    start_req(1'b1, 1'b0, 9'h010, 32'h0);
    wait_done(2, lat, ok);
    checks++;
    if (!ok || lat != 11 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_latency: done=%0d cycle=%0d rd_valid=%b, required completion in cycle 11", ok, lat, rd_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (err !== e.err || rd_data !== e.data) begin
        errors++; $display("FAIL timeout_result: err=%b rd_data=%h, required %b %h", err, rd_data, e.err, e.data);
      end
    end
    @(negedge clock);
    checks++;
    if (err !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: err=%b rd_valid=%b required 0 0", err, rd_valid);
    end
    hold_done = 1'b0;
  endtask

  task automatic test_reset_mid_access;
    int pulses = 0;
    start_req(1'b1, 1'b0, 9'h1A5, 32'h0);
    @(negedge clock);
    checks++;
    if (mem_enable !== 1'b1) begin
      errors++; $display("FAIL rst_mid_strobe: mem_enable=%b required 1", mem_enable);
    end
    clear = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, rd_valid, wr_ack, err, mem_read, mem_write, mem_enable, rd_data, mem_address, mem_data_in} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%b en=%b rd=%b rd_data=%h addr=%h, required all zero",
               busy, mem_enable, mem_read, rd_data, mem_address);
    end
    clear = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (rd_valid || wr_ack) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL rst_mid_abandon: completions=%0d required 0", pulses);
    end
  endtask

  task automatic test_request_while_busy;
    exp_t e;
    int   rd_n = 0;
    int   wr_n = 0;
    preload(9'h055, 32'h0BADF00D);
    exp_q.push_back('{is_read: 1'b1, data: 32'hDEADBEEF, err: 1'b0});
    start_req(1'b1, 1'b0, 9'h1A5, 32'h0);
    @(negedge clock);
    @(negedge clock);
    req_write = 1'b1; req_addr = 9'h055; req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      req_write = 1'b0;
      if (wr_ack) wr_n++;
      if (rd_valid) begin
        rd_n++;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e.data || err !== e.err) begin
          errors++; $display("FAIL busy_req_data: rd_data=%h err=%b, required %h %b", rd_data, err, e.data, e.err);
        end
      end
    end
    checks++;
    if (rd_n != 1 || wr_n != 0 || mem[9'h055] !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL busy_req_ignored: rd_valid=%0d wr_ack=%0d mem[055]=%h, required 1 0 0badf00d", rd_n, wr_n, mem[9'h055]);
    end
  endtask

  initial begin
    clear = 1'b0; req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clock);
    test_reset();
    test_read();
    test_write_then_read();
    test_simultaneous();
    test_timeout();
    test_reset_mid_access();
    test_request_while_busy();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected completions outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
